// File: rtl/fetch_unit.sv
// Solix-16 instruction fetch stage: req/ack fetches from instruction memory, advances the PC
// through the register file and queues fetched words for decode, flushing on redirect.
module fetch_unit #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned PC_INC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_cur,
  output logic [15:0] pc_next,
  output logic        pc_wr,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        inst_valid,
  output logic [15:0] inst_data,
  output logic [15:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  typedef struct packed {
    logic [15:0] data;
    logic [15:0] pc;
  } entry_t;

  state_t          state_q, state_d;
  logic            req_q, req_d;
  logic [15:0]     addr_q, addr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic            valid_q;
  entry_t          head_q, head_d;
  entry_t          mem [DEPTH];

  logic            xfer, push, pop, space;
  logic [15:0]     pc_inc;
  entry_t          new_entry;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign xfer      = req_q & imem_ack;
  assign push      = (state_q == FETCH) & xfer & ~redirect;
  assign pop       = valid_q & inst_ready & ~redirect;
  assign pc_inc    = pc_cur + 16'(PC_INC);
  assign new_entry = '{data: imem_rdata, pc: addr_q};

  // Buffer bookkeeping; a redirect empties the buffer on the same edge.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    head_d   = head_q;
    if (redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (pop && count_q >= CW'(2)) begin
        head_d = mem[ptr_inc(rd_ptr_q)];
      end else if (push && (count_q == '0 || (pop && count_q == CW'(1)))) begin
        head_d = new_entry;
      end
    end
  end

  assign space = count_d < CW'(DEPTH);

  // Next-state and request/address control.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (!redirect && space) begin
          req_d   = 1'b1;
          addr_d  = pc_cur;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (redirect) begin
          if (xfer) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end else if (xfer) begin
          if (space) begin
            addr_d = pc_inc;
          end else begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (xfer) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Register-file PC write port; redirect wins over the fetch increment.
  always_comb begin
    pc_wr   = 1'b0;
    pc_next = pc_cur;
    if (rst_n) begin
      if (redirect) begin
        pc_wr   = 1'b1;
        pc_next = redirect_pc;
      end else if (push) begin
        pc_wr   = 1'b1;
        pc_next = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      addr_q   <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      valid_q  <= (count_d != '0);
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= new_entry;
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_valid = valid_q;
  assign inst_data  = head_q.data;
  assign inst_pc    = head_q.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, directed corner sequences and a randomized run
// against a transaction-level model of the fetch stream.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc_cur, pc_next, imem_addr, imem_rdata, redirect_pc, inst_data, inst_pc;
  logic        pc_wr, imem_req, imem_ack, redirect, inst_valid, inst_ready;
  logic [15:0] pc_reg;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.DEPTH(DEPTH), .PC_INC(1)) dut (
    .clk(clk), .rst_n(rst_n), .pc_cur(pc_cur), .pc_next(pc_next), .pc_wr(pc_wr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word_at(input logic [15:0] a);
    return (a ^ 16'h5A5A) + 16'h1234;
  endfunction

  // Register file PC and instruction memory
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_reg <= 16'h0000;
    else if (pc_wr) pc_reg <= pc_next;
  end
  assign pc_cur     = pc_reg;
  assign imem_rdata = word_at(imem_addr);

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%04h required=%04h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0000;
    imem_ack = 1'b0;
    inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic        rst;
    logic        ack;
    logic        rdy;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_ipc;
    logic        e_pcwr;
    logic [15:0] e_next;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic ack, input logic rdy,
                              input logic e_req, input logic [15:0] e_addr,
                              input logic e_valid, input logic [15:0] e_ipc,
                              input logic e_pcwr, input logic [15:0] e_next);
    return '{rst: rst, ack: ack, rdy: rdy, e_req: e_req, e_addr: e_addr, e_valid: e_valid,
             e_ipc: e_ipc, e_pcwr: e_pcwr, e_next: e_next};
  endfunction

  vec_t vec [13];

  // Random-phase model state
  logic [15:0] fetch_pc, exp_pc, prev_addr;
  int          occ, pops;
  logic        stale, prev_wait, fresh;

  initial begin
    // Back-to-back stream with everything ready, then a full buffer stalling decode
    vec[0]  = mk(1, 1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    vec[1]  = mk(0, 1, 1, 1, 16'h0000, 0, 16'h0000, 1, 16'h0001);
    vec[2]  = mk(0, 1, 1, 1, 16'h0001, 1, 16'h0000, 1, 16'h0002);
    vec[3]  = mk(0, 1, 1, 1, 16'h0002, 1, 16'h0001, 1, 16'h0003);
    vec[4]  = mk(0, 1, 1, 1, 16'h0003, 1, 16'h0002, 1, 16'h0004);
    vec[5]  = mk(1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    vec[6]  = mk(0, 1, 0, 1, 16'h0000, 0, 16'h0000, 1, 16'h0001);
    vec[7]  = mk(0, 1, 0, 1, 16'h0001, 1, 16'h0000, 1, 16'h0002);
    vec[8]  = mk(0, 1, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0002);
    vec[9]  = mk(0, 1, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0002);
    vec[10] = mk(0, 1, 1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0002);
    vec[11] = mk(0, 1, 1, 1, 16'h0002, 1, 16'h0001, 1, 16'h0003);
    vec[12] = mk(0, 1, 1, 1, 16'h0003, 1, 16'h0002, 1, 16'h0004);

    redirect = 1'b1;
    redirect_pc = 16'h1234;
    imem_ack = 1'b1;
    inst_ready = 1'b1;
    #12;
    chk1("reset_req", imem_req, 1'b0);
    chk16("reset_addr", imem_addr, 16'h0000);
    chk1("reset_valid", inst_valid, 1'b0);
    chk16("reset_data", inst_data, 16'h0000);
    chk16("reset_ipc", inst_pc, 16'h0000);
    chk1("reset_pcwr", pc_wr, 1'b0);

    for (int i = 0; i < 13; i++) begin
      if (vec[i].rst) do_reset();
      imem_ack = vec[i].ack;
      inst_ready = vec[i].rdy;
      sample();
      chk1($sformatf("v%0d_req", i), imem_req, vec[i].e_req);
      if (vec[i].e_req) chk16($sformatf("v%0d_addr", i), imem_addr, vec[i].e_addr);
      chk1($sformatf("v%0d_valid", i), inst_valid, vec[i].e_valid);
      if (vec[i].e_valid) begin
        chk16($sformatf("v%0d_ipc", i), inst_pc, vec[i].e_ipc);
        chk16($sformatf("v%0d_data", i), inst_data, word_at(vec[i].e_ipc));
      end
      chk1($sformatf("v%0d_pcwr", i), pc_wr, vec[i].e_pcwr);
      chk16($sformatf("v%0d_pcnext", i), pc_next, vec[i].e_next);
      tick();
    end

    // Ack delayed three cycles
    do_reset();
    inst_ready = 1'b1;
    sample(); chk1("d3_idle_req", imem_req, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      sample();
      chk1("d3_wait_req", imem_req, 1'b1);
      chk16("d3_wait_addr", imem_addr, 16'h0000);
      chk1("d3_wait_pcwr", pc_wr, 1'b0);
      tick();
    end
    imem_ack = 1'b1;
    sample(); chk1("d3_ack_pcwr", pc_wr, 1'b1); chk16("d3_ack_next", pc_next, 16'h0001); tick();
    imem_ack = 1'b0;
    sample();
    chk16("d3_next_addr", imem_addr, 16'h0001);
    chk1("d3_after_pcwr", pc_wr, 1'b0);
    chk1("d3_valid", inst_valid, 1'b1);
    chk16("d3_ipc", inst_pc, 16'h0000);
    chk16("d3_data", inst_data, word_at(16'h0000));
    tick();

    // Redirect while a request waits: drain and refetch from target
    do_reset();
    inst_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 16'h0005;
    sample(); chk1("rd_idle_pcwr", pc_wr, 1'b1); chk16("rd_idle_next", pc_next, 16'h0005); tick();
    redirect = 1'b0;
    sample(); chk1("rd_idle_hold", imem_req, 1'b0); tick();
    sample(); chk1("rd_req5", imem_req, 1'b1); chk16("rd_addr5", imem_addr, 16'h0005); tick();
    redirect = 1'b1; redirect_pc = 16'h0100;
    sample(); chk16("rd_next100", pc_next, 16'h0100); tick();
    redirect = 1'b0;
    sample(); chk1("rd_drain_req", imem_req, 1'b1); chk16("rd_drain_addr", imem_addr, 16'h0005);
    chk1("rd_drain_valid", inst_valid, 1'b0); tick();
    imem_ack = 1'b1;
    sample(); chk1("rd_drain_ack_pcwr", pc_wr, 1'b0); tick();
    imem_ack = 1'b0;
    sample(); chk1("rd_post_req", imem_req, 1'b0); chk1("rd_post_valid", inst_valid, 1'b0);
    chk16("rd_post_pc", pc_cur, 16'h0100); tick();
    imem_ack = 1'b1;
    sample(); chk16("rd_addr100", imem_addr, 16'h0100); chk16("rd_next101", pc_next, 16'h0101); tick();
    imem_ack = 1'b0;
    sample(); chk1("rd_valid100", inst_valid, 1'b1); chk16("rd_ipc100", inst_pc, 16'h0100); tick();

    // Redirect coinciding with ack
    do_reset();
    inst_ready = 1'b1;
    imem_ack = 1'b1;
    sample(); tick();
    redirect = 1'b1; redirect_pc = 16'h0040;
    sample(); chk1("ra_req", imem_req, 1'b1); chk16("ra_next", pc_next, 16'h0040); tick();
    redirect = 1'b0;
    sample(); chk1("ra_req_drop", imem_req, 1'b0); chk1("ra_valid", inst_valid, 1'b0);
    chk16("ra_pc", pc_cur, 16'h0040); tick();
    sample(); chk1("ra_req40", imem_req, 1'b1); chk16("ra_addr40", imem_addr, 16'h0040); tick();

    // PC wrap at FFFF, then async reset mid-wait
    do_reset();
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    sample(); tick();
    redirect = 1'b0;
    sample(); tick();
    imem_ack = 1'b1;
    sample(); chk16("wr_addr", imem_addr, 16'hFFFF); chk1("wr_pcwr", pc_wr, 1'b1);
    chk16("wr_next", pc_next, 16'h0000); tick();
    imem_ack = 1'b0;
    sample(); chk16("wr_addr0", imem_addr, 16'h0000); chk1("wr_valid", inst_valid, 1'b1);
    chk16("wr_ipc", inst_pc, 16'hFFFF); chk16("wr_pc", pc_cur, 16'h0000); tick();
    #2 rst_n = 1'b0;
    #1;
    chk1("ar_req", imem_req, 1'b0);
    chk1("ar_valid", inst_valid, 1'b0);
    chk1("ar_pcwr", pc_wr, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Randomized run against the fetch-stream model
    do_reset();
    fetch_pc = 16'h0000; exp_pc = 16'h0000; prev_addr = 16'h0000;
    occ = 0; pops = 0; stale = 1'b0; prev_wait = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      imem_ack = ($urandom_range(0, 9) < 6);
      inst_ready = ($urandom_range(0, 9) < 6);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = 16'($urandom);
      sample();
      if (prev_wait) begin
        chk1("rnd_req_held", imem_req, 1'b1);
        chk16("rnd_addr_held", imem_addr, prev_addr);
      end
      chk1("rnd_valid", inst_valid, occ != 0);
      if (inst_valid && inst_ready && !redirect) begin
        chk16("rnd_ipc", inst_pc, exp_pc);
        chk16("rnd_data", inst_data, word_at(inst_pc));
        exp_pc = exp_pc + 16'd1;
        occ--;
        pops++;
      end
      fresh = imem_req && imem_ack && !stale && !redirect;
      if (redirect) begin
        chk1("rnd_redir_pcwr", pc_wr, 1'b1);
        chk16("rnd_redir_next", pc_next, redirect_pc);
        occ = 0;
        fetch_pc = redirect_pc;
        exp_pc = redirect_pc;
        stale = imem_req && !imem_ack;
      end else if (fresh) begin
        chk16("rnd_fetch_addr", imem_addr, fetch_pc);
        chk1("rnd_inc_pcwr", pc_wr, 1'b1);
        chk16("rnd_inc_next", pc_next, imem_addr + 16'd1);
        fetch_pc = fetch_pc + 16'd1;
        occ++;
      end else begin
        chk1("rnd_idle_pcwr", pc_wr, 1'b0);
        if (imem_req && imem_ack) stale = 1'b0;
      end
      if (occ > DEPTH) begin
        errors++;
        $display("FAIL rnd_occupancy actual=%0d required<=%0d", occ, DEPTH);
      end
      prev_wait = imem_req && !imem_ack;
      prev_addr = imem_addr;
      tick();
    end
    checks++;
    if (pops < 200) begin
      errors++;
      $display("FAIL rnd_progress actual=%0d required>=200", pops);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
